// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt controller: synchronised edge-latched sources, enable mask,
// fixed priority and a return-PC/priority stack for nested preemption.
module irq_vector_ctrl #(
    parameter  int NUM_SRC    = 8,
    parameter  int PC_WIDTH   = 16,
    parameter  int VEC_STRIDE = 4,
    parameter  int NEST_DEPTH = 2,
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DW = $clog2(NEST_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_n,
    input  logic                sw_req,
    input  logic [IW-1:0]       sw_idx,
    input  logic                eret_n,
    input  logic [PC_WIDTH-1:0] current_pc,
    input  logic                mask_we,
    input  logic [NUM_SRC-1:0]  mask_wdata,
    input  logic                ie_set,
    input  logic                ie_clr,
    output logic                int_take,
    output logic [PC_WIDTH-1:0] int_pc,
    output logic                ret_valid,
    output logic [PC_WIDTH-1:0] ret_pc,
    output logic [NUM_SRC-1:0]  pending,
    output logic [DW-1:0]       depth,
    output logic                err_underflow
);

    logic [NUM_SRC-1:0]  s1_q, s1_d;
    logic [NUM_SRC-1:0]  s2_q, s2_d;
    logic [NUM_SRC-1:0]  s3_q, s3_d;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [NUM_SRC-1:0]  mask_q, mask_d;
    logic                ie_q, ie_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic                err_q, err_d;
    logic                int_take_q, int_take_d;
    logic [PC_WIDTH-1:0] int_pc_q, int_pc_d;
    logic                ret_valid_q, ret_valid_d;
    logic [PC_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic [PC_WIDTH-1:0] pc_stk_q [NEST_DEPTH];
    logic [PC_WIDTH-1:0] pc_stk_d [NEST_DEPTH];
    logic [IW-1:0]       pri_stk_q [NEST_DEPTH];
    logic [IW-1:0]       pri_stk_d [NEST_DEPTH];

    logic [NUM_SRC-1:0]  fall;
    logic [NUM_SRC-1:0]  sw_set;
    logic [NUM_SRC-1:0]  req;
    logic                cand_vld;
    logic [IW-1:0]       cand_idx;
    logic [IW-1:0]       top_pri;
    logic                do_take;
    logic                do_ret;

    always_comb begin
        s1_d = irq_n;
        s2_d = s1_q;
        s3_d = s2_q;
        fall = ~s2_q & s3_q;

        sw_set = '0;
        if (sw_req && (int'(sw_idx) < NUM_SRC)) begin
            sw_set[sw_idx] = 1'b1;
        end

        req      = pending_q & mask_q;
        cand_vld = 1'b0;
        cand_idx = '0;
        // Walk downwards so the lowest requesting index is the one left standing
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                cand_vld = 1'b1;
                cand_idx = IW'(i);
            end
        end

        top_pri = '0;
        for (int j = 0; j < NEST_DEPTH; j++) begin
            if (DW'(j + 1) == depth_q) begin
                top_pri = pri_stk_q[j];
            end
        end

        do_ret  = !eret_n && (depth_q != '0);
        // Any eret cycle blocks a take; the take is re-evaluated next cycle
        do_take = ie_q && cand_vld && eret_n
                  && (depth_q < DW'(NEST_DEPTH))
                  && ((depth_q == '0) || (cand_idx < top_pri));

        pc_stk_d  = pc_stk_q;
        pri_stk_d = pri_stk_q;
        pending_d = pending_q;
        depth_d   = depth_q;
        int_pc_d  = '0;
        ret_pc_d  = '0;

        if (do_take) begin
            for (int j = 0; j < NEST_DEPTH; j++) begin
                if (DW'(j) == depth_q) begin
                    pc_stk_d[j]  = current_pc;
                    pri_stk_d[j] = cand_idx;
                end
            end
            pending_d[cand_idx] = 1'b0;
            depth_d  = depth_q + DW'(1);
            int_pc_d = PC_WIDTH'(int'(cand_idx) * VEC_STRIDE);
        end

        if (do_ret) begin
            for (int j = 0; j < NEST_DEPTH; j++) begin
                if (DW'(j + 1) == depth_q) begin
                    ret_pc_d = pc_stk_q[j];
                end
            end
            depth_d = depth_q - DW'(1);
        end

        // New events on this edge survive a take of the same source
        pending_d = pending_d | fall | sw_set;

        mask_d = mask_we ? mask_wdata : mask_q;

        ie_d = ie_q;
        if (ie_clr) begin
            ie_d = 1'b0;
        end else if (ie_set) begin
            ie_d = 1'b1;
        end

        err_d       = err_q | (!eret_n && (depth_q == '0));
        int_take_d  = do_take;
        ret_valid_d = do_ret;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= '1;
            s2_q        <= '1;
            s3_q        <= '1;
            pending_q   <= '0;
            mask_q      <= '0;
            ie_q        <= 1'b0;
            depth_q     <= '0;
            err_q       <= 1'b0;
            int_take_q  <= 1'b0;
            int_pc_q    <= '0;
            ret_valid_q <= 1'b0;
            ret_pc_q    <= '0;
            for (int j = 0; j < NEST_DEPTH; j++) begin
                pc_stk_q[j]  <= '0;
                pri_stk_q[j] <= '0;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            ie_q        <= ie_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            int_take_q  <= int_take_d;
            int_pc_q    <= int_pc_d;
            ret_valid_q <= ret_valid_d;
            ret_pc_q    <= ret_pc_d;
            for (int j = 0; j < NEST_DEPTH; j++) begin
                pc_stk_q[j]  <= pc_stk_d[j];
                pri_stk_q[j] <= pri_stk_d[j];
            end
        end
    end

    assign int_take      = int_take_q;
    assign int_pc        = int_pc_q;
    assign ret_valid     = ret_valid_q;
    assign ret_pc        = ret_pc_q;
    assign pending       = pending_q;
    assign depth         = depth_q;
    assign err_underflow = err_q;

endmodule
